// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// The producer/consumer side uses the master modport; the adder stage uses slave.
interface multiword_add_seq_if #(
  parameter int width = 2,
  parameter int CNT_W = 4
) ();
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [width:0]   a;
  logic [width:0]   b;
  logic             first;
  logic             last;
  logic             cin_init;
  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [width:0]   sum;
  logic [CNT_W-1:0] out_idx;
  logic             out_last;
  logic             carry_out;
  logic             err_restart;

  modport master (
    output in_valid, a, b, first, last, cin_init, out_ready,
    input  in_ready, out_valid, sum, out_idx, out_last, carry_out, err_restart
  );

  modport slave (
    input  in_valid, a, b, first, last, cin_init, out_ready,
    output in_ready, out_valid, sum, out_idx, out_last, carry_out, err_restart
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: accepts operand words LS-word first, chains the
// carry between words of a packet and registers each sum word for a
// valid/ready consumer. One word per cycle, one cycle of latency.
module multiword_add_seq #(
  parameter int width = 2,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multiword_add_seq_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [width:0]   sum_q, sum_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             carry_out_q, carry_out_d;
  logic             err_q, err_d;

  logic             accept;
  logic             new_pkt;
  logic             cin_sel;
  logic [width+1:0] sum_wide;
  logic [CNT_W-1:0] word_idx;

  // The stage can take a word whenever the output register is empty or being drained.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // A word starts a packet when nothing is open or when the producer flags it as first.
  assign new_pkt  = (state_q == IDLE) || bus.first;
  assign cin_sel  = new_pkt ? bus.cin_init : carry_q;
  assign word_idx = new_pkt ? '0 : idx_q;

  // Full-width add: the extra top bit is the word's carry out.
  assign sum_wide = {1'b0, bus.a} + {1'b0, bus.b} + {{(width + 1){1'b0}}, cin_sel};

  // Next-state, datapath load and retire logic.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    carry_out_d = carry_out_q;
    err_d       = err_q;

    if (accept) begin
      sum_d       = sum_wide[width:0];
      carry_out_d = sum_wide[width+1];
      carry_d     = sum_wide[width+1];
      out_last_d  = bus.last;
      out_idx_d   = word_idx;
      out_valid_d = 1'b1;
      idx_d       = word_idx + 1'b1;
      state_d     = bus.last ? IDLE : IN_PKT;
      if ((state_q == IN_PKT) && bus.first) begin
        err_d = 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.sum         = sum_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.out_last    = out_last_q;
  assign bus.carry_out   = carry_out_q;
  assign bus.err_restart = err_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (width=2, CNT_W=2 so the index wrap is reachable).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_multiword_add_seq;

  localparam int W  = 2;
  localparam int CW = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  multiword_add_seq_if #(.width(W), .CNT_W(CW)) ifc ();

  multiword_add_seq #(.width(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed result bundle: {out_valid, sum[2:0], carry_out, out_last, out_idx[1:0]}
  function automatic logic [7:0] obs();
    return {ifc.out_valid, ifc.sum, ifc.carry_out, ifc.out_last, ifc.out_idx};
  endfunction

  function automatic logic [7:0] exp_vec(input int v, input int s, input int c,
                                         input int l, input int i);
    logic [7:0] r;
    r = {v[0], s[2:0], c[0], l[0], i[1:0]};
    return r;
  endfunction

  task automatic drive(input bit v, input int av, input int bv, input bit f,
                       input bit l, input bit ci);
    logic [W:0] ta;
    logic [W:0] tb;
    ta = av[W:0];
    tb = bv[W:0];
    ifc.in_valid = v;
    ifc.a        = ta;
    ifc.b        = tb;
    ifc.first    = f;
    ifc.last     = l;
    ifc.cin_init = ci;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    ifc.out_ready = 1'b1;
    rst_n = 1'b0;
    #7;
    n_cmp++;
    if ({obs(), ifc.err_restart} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want %b", {obs(), ifc.err_restart}, 9'd0);
    end
    n_cmp++;
    if (ifc.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b want 1", ifc.in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    @(negedge clk);
    drive(1, 5, 6, 1, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (obs() !== exp_vec(1, 4, 1, 1, 0)) begin
      n_bad++;
      $display("FAIL single_word got %b want %b", obs(), exp_vec(1, 4, 1, 1, 0));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ifc.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_retire out_valid got %b want 0", ifc.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1, 7, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 2, 3, 0, 1, 0);
    #1;
    n_cmp++;
    if (obs() !== exp_vec(1, 0, 1, 0, 0)) begin
      n_bad++;
      $display("FAIL b2b_word0 got %b want %b", obs(), exp_vec(1, 0, 1, 0, 0));
    end
    n_cmp++;
    if (ifc.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_in_ready got %b want 1", ifc.in_ready);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (obs() !== exp_vec(1, 6, 0, 1, 1)) begin
      n_bad++;
      $display("FAIL b2b_word1 got %b want %b", obs(), exp_vec(1, 6, 0, 1, 1));
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(1, 7, 2, 1, 0, 0);          // 9 -> sum 1, carry 1
    @(negedge clk);
    ifc.out_ready = 1'b0;
    drive(1, 1, 1, 0, 1, 0);          // must wait; 1+1+carry 1 -> 3
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_in_ready cycle %0d got %b want 0", k, ifc.in_ready);
      end
      n_cmp++;
      if (obs() !== exp_vec(1, 1, 1, 0, 0)) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d got %b want %b", k, obs(), exp_vec(1, 1, 1, 0, 0));
      end
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (ifc.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_in_ready got %b want 1", ifc.in_ready);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (obs() !== exp_vec(1, 3, 0, 1, 1)) begin
      n_bad++;
      $display("FAIL bp_next_word got %b want %b", obs(), exp_vec(1, 3, 0, 1, 1));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ifc.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_no_duplicate out_valid got %b want 0", ifc.out_valid);
    end
  endtask

  task automatic test_restart();
    @(negedge clk);
    drive(1, 7, 7, 1, 0, 0);          // 14 -> sum 6, carry 1
    @(negedge clk);
    drive(1, 1, 0, 1, 1, 0);          // restart: cin_init 0, idx 0
    #1;
    n_cmp++;
    if ({obs(), ifc.err_restart} !== {exp_vec(1, 6, 1, 0, 0), 1'b0}) begin
      n_bad++;
      $display("FAIL restart_word0 got %b want %b", {obs(), ifc.err_restart},
               {exp_vec(1, 6, 1, 0, 0), 1'b0});
    end
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0);          // a later single-word packet
    #1;
    n_cmp++;
    if ({obs(), ifc.err_restart} !== {exp_vec(1, 1, 0, 1, 0), 1'b1}) begin
      n_bad++;
      $display("FAIL restart_word got %b want %b", {obs(), ifc.err_restart},
               {exp_vec(1, 1, 0, 1, 0), 1'b1});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({obs(), ifc.err_restart} !== {exp_vec(1, 0, 0, 1, 0), 1'b1}) begin
      n_bad++;
      $display("FAIL restart_sticky got %b want %b", {obs(), ifc.err_restart},
               {exp_vec(1, 0, 0, 1, 0), 1'b1});
    end
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    drive(1, 7, 1, 1, 0, 0);          // 8 -> sum 0, carry 1
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (obs() !== exp_vec(1, 0, 1, 0, 0)) begin
      n_bad++;
      $display("FAIL rst_mid_word0 got %b want %b", obs(), exp_vec(1, 0, 1, 0, 0));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs(), ifc.err_restart} !== 9'd0) begin
      n_bad++;
      $display("FAIL rst_mid_cleared got %b want %b", {obs(), ifc.err_restart}, 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1, 0, 1, 0);          // first=0 after reset: fresh packet, carry ignored
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (obs() !== exp_vec(1, 2, 0, 1, 0)) begin
      n_bad++;
      $display("FAIL rst_mid_next got %b want %b", obs(), exp_vec(1, 2, 0, 1, 0));
    end
  endtask

  task automatic test_index_wrap();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1, 7, 0, k == 0, k == 4, 1);
      if (k > 0) begin
        #1;
        n_cmp++;
        if (obs() !== exp_vec(1, 0, 1, 0, exp_idx[k-1])) begin
          n_bad++;
          $display("FAIL wrap_word%0d got %b want %b", k - 1, obs(),
                   exp_vec(1, 0, 1, 0, exp_idx[k-1]));
        end
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (obs() !== exp_vec(1, 0, 1, 1, exp_idx[4])) begin
      n_bad++;
      $display("FAIL wrap_word4 got %b want %b", obs(), exp_vec(1, 0, 1, 1, exp_idx[4]));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ifc.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_restart();
    test_reset_mid_packet();
    test_index_wrap();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a run that never completes.
  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
